shift_sched: RTL and testbench
==============================

SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter SHW, default 3, shift-amount width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  shift request from requester 0/1; held high until granted.
REQ-006 SHALL have ports data0/data1  input  WIDTH  operand from requester 0/1.
REQ-007 SHALL have ports amt0/amt1  input  SHW  left-shift amount from requester 0/1.
REQ-008 SHALL have port gnt  output  2  one-hot registered grant pulse; bit i = requester i accepted.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port result  output  WIDTH  shifted operand; held until next done.
REQ-012 SHALL have port owner  output  1  requester index of the current result.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE with a single shared serial shift engine (accumulator acc, counter cnt).
REQ-014 In IDLE, on an edge with req0 or req1 high: select a winner (REQ-019/020), load acc<=data, cnt<=amt, owner<=winner, go SHIFT; gnt[winner]=1 for exactly the following cycle.
REQ-015 In SHIFT, each edge: if cnt==0 then result<=acc, go DONE; else acc<=acc<<1 (zero into LSB, MSB discarded), cnt<=cnt-1.
REQ-016 In DONE, done=1 for that cycle; next edge go IDLE unconditionally (no request sampled in DONE).
REQ-017 Latency: done high amt+1 cycles after the grant cycle begins (amt=0 -> done in cycle after gnt); back-to-back issue interval amt+3 cycles.
REQ-018 Result SHALL equal (data << amt) truncated to WIDTH bits; amt >= WIDTH yields 0.
REQ-019 Single requester high in IDLE: that requester wins.
REQ-020 Both high in IDLE: requester 0 wins (fixed priority) unless REQ-026 applies.
REQ-021 Requests, data and amt changes outside the accept edge SHALL be ignored; a losing requester stays pending and is served on a later IDLE edge.
REQ-022 A req deasserted before its accept edge SHALL cause no grant and no operation.
REQ-023 gnt SHALL never have both bits set; done and gnt SHALL never be high in the same cycle.

Reset
REQ-024 reset high SHALL immediately force: state IDLE, gnt=0, busy=0, done=0, result=0, owner=0, acc=0, cnt=0, round-robin pointer=0.
REQ-025 Reset during SHIFT or DONE SHALL abort the operation with no done pulse; first accept possible on the first edge after reset deasserts.

Configuration
REQ-026 With macro SHIFT_SCHED_RR_EN defined: round-robin arbitration; when both request, the requester not granted last wins; pointer resets to favour requester 0; single-requester behaviour unchanged. Without it: fixed priority per REQ-020, no pointer state.

Verification
REQ-027 req0, data0=01, amt0=0 -> gnt=01 next cycle, done one cycle later, result=01, owner=0.
REQ-028 req1, data1=01, amt1=7 -> done 8 cycles after gnt, result=80, owner=1; then data1=a5, amt1=7 -> 80; data1=a5, amt1=1 -> 4a.
REQ-029 req0 and req1 held high together (data 01/amt 2, data 01/amt 3), fixed priority -> result 04 owner 0, then 08 owner 1; with SHIFT_SCHED_RR_EN and both held continuously -> owners alternate 0,1,0,1.
REQ-030 reset pulsed mid-SHIFT (amt=5) -> outputs zero at once, no done, next request completes normally.
REQ-031 SHW=4, data=ff, amt=9 -> result=00 after 10 cycles; amt=8 -> 00; amt=7 -> 80.

Source files
------------

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - two-requester arbitrated serial left-shift engine
// Define SHIFT_SCHED_RR_EN for round-robin arbitration (default: fixed priority, requester 0 first).
module shift_sched #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [SHW-1:0]   amt0,
  input  logic [SHW-1:0]   amt1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             owner_q, owner_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             win;

`ifdef SHIFT_SCHED_RR_EN
  // rr_q names the requester favoured on the next contested accept
  logic rr_q, rr_d;

  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = rr_q;
    end else begin
      win = req1;
    end
  end
`else
  always_comb begin
    win = !req0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    owner_d  = owner_q;
    gnt_d    = 2'b00;
`ifdef SHIFT_SCHED_RR_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          acc_d   = win ? data1 : data0;
          cnt_d   = win ? amt1 : amt0;
          owner_d = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          state_d = SHIFT;
`ifdef SHIFT_SCHED_RR_EN
          rr_d    = !win;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          result_d = acc_q;
          state_d  = DONE;
        end else begin
          acc_d = {acc_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - SHW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      owner_q  <= 1'b0;
      gnt_q    <= 2'b00;
`ifdef SHIFT_SCHED_RR_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
`ifdef SHIFT_SCHED_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - directed self-checking bench for shift_sched
// Second instance uses SHW=4 to reach shift amounts beyond WIDTH.
module tb_shift_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic [2:0] amt0 = '0, amt1 = '0;
  logic [1:0] gnt;
  logic       busy, done, owner;
  logic [7:0] result;

  logic       b_req0 = 1'b0, b_req1 = 1'b0;
  logic [7:0] b_data0 = '0, b_data1 = '0;
  logic [3:0] b_amt0 = '0, b_amt1 = '0;
  logic [1:0] b_gnt;
  logic       b_busy, b_done, b_owner;
  logic [7:0] b_result;

  int total = 0;
  int bad = 0;

  shift_sched #(.WIDTH(8), .SHW(3)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1), .amt0(amt0), .amt1(amt1),
    .gnt(gnt), .busy(busy), .done(done), .result(result), .owner(owner)
  );

  shift_sched #(.WIDTH(8), .SHW(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .req1(b_req1), .data0(b_data0), .data1(b_data1), .amt0(b_amt0), .amt1(b_amt1),
    .gnt(b_gnt), .busy(b_busy), .done(b_done), .result(b_result), .owner(b_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the grant, optionally drops the granted request, then times the done pulse.
  task automatic run_op(input string tag, input bit sel, input logic [1:0] exp_gnt,
                        input int exp_lat, input logic [7:0] exp_res, input logic exp_own,
                        input bit drop);
    int n;
    logic [1:0] g;
    logic d;
    n = 0;
    g = 2'b00;
    while (n < 30) begin
      @(posedge clk); #1;
      n++;
      g = sel ? b_gnt : gnt;
      if (g != 2'b00) break;
    end
    check({tag, "_gnt"}, 32'(g), 32'(exp_gnt));
    if (drop) begin
      if (sel) begin
        b_req0 = 1'b0;
        b_req1 = 1'b0;
      end else begin
        if (g[0]) req0 = 1'b0;
        if (g[1]) req1 = 1'b0;
      end
    end
    n = 0;
    d = 1'b0;
    while (n < 40 && !d) begin
      @(posedge clk); #1;
      n++;
      d = sel ? b_done : done;
    end
    check({tag, "_done"}, 32'(d), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_gnt_at_done"}, 32'(sel ? b_gnt : gnt), 32'd0);
    check({tag, "_result"}, 32'(sel ? b_result : result), 32'(exp_res));
    check({tag, "_owner"}, 32'(sel ? b_owner : owner), 32'(exp_own));
  endtask

  initial begin
    int n;
    logic seen;
    int exp_own;

    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    req0 = 1'b1; data0 = 8'h01; amt0 = 3'd0;
    run_op("r27", 1'b0, 2'b01, 1, 8'h01, 1'b0, 1'b1);

    req1 = 1'b1; data1 = 8'h01; amt1 = 3'd7;
    run_op("r28a", 1'b0, 2'b10, 8, 8'h80, 1'b1, 1'b1);
    req1 = 1'b1; data1 = 8'ha5; amt1 = 3'd7;
    run_op("r28b", 1'b0, 2'b10, 8, 8'h80, 1'b1, 1'b1);
    req1 = 1'b1; data1 = 8'ha5; amt1 = 3'd1;
    run_op("r28c", 1'b0, 2'b10, 2, 8'h4a, 1'b1, 1'b1);

    // request raised in DONE and dropped before the IDLE edge must be ignored
    req1 = 1'b1;
    @(posedge clk); #1;
    check("r22_idle", 32'(busy), 32'd0);
    req1 = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | (|gnt) | busy;
    end
    check("r22_no_op", 32'(seen), 32'd0);

    req0 = 1'b1; data0 = 8'h01; amt0 = 3'd2;
    req1 = 1'b1; data1 = 8'h01; amt1 = 3'd3;
    run_op("r29a", 1'b0, 2'b01, 3, 8'h04, 1'b0, 1'b1);
    run_op("r29b", 1'b0, 2'b10, 4, 8'h08, 1'b1, 1'b1);

    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_SCHED_RR_EN
      exp_own = i % 2;
`else
      exp_own = 0;
`endif
      run_op($sformatf("r29_hold%0d", i), 1'b0, (exp_own != 0) ? 2'b10 : 2'b01,
             (exp_own != 0) ? 4 : 3, (exp_own != 0) ? 8'h08 : 8'h04, exp_own[0], 1'b0);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    req0 = 1'b1; data0 = 8'h01; amt0 = 3'd5;
    n = 0;
    while (n < 10 && gnt == 2'b00) begin
      @(posedge clk); #1;
      n++;
    end
    check("r30_gnt", 32'(gnt), 32'd1);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("r30_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("r30_rst_busy", 32'(busy), 32'd0);
    check("r30_rst_done", 32'(done), 32'd0);
    check("r30_rst_gnt", 32'(gnt), 32'd0);
    check("r30_rst_result", 32'(result), 32'd0);
    check("r30_rst_owner", 32'(owner), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    check("r30_no_done", 32'(seen), 32'd0);

    // both pending after reset: pointer (if any) must favour requester 0 again
    req0 = 1'b1; data0 = 8'h03; amt0 = 3'd2;
    req1 = 1'b1; data1 = 8'hff; amt1 = 3'd1;
    run_op("r30b", 1'b0, 2'b01, 3, 8'h0c, 1'b0, 1'b1);
    run_op("r30c", 1'b0, 2'b10, 2, 8'hfe, 1'b1, 1'b1);

    b_req0 = 1'b1; b_data0 = 8'hff; b_amt0 = 4'd9;
    run_op("r31a", 1'b1, 2'b01, 10, 8'h00, 1'b0, 1'b1);
    b_req0 = 1'b1; b_amt0 = 4'd8;
    run_op("r31b", 1'b1, 2'b01, 9, 8'h00, 1'b0, 1'b1);
    b_req0 = 1'b1; b_amt0 = 4'd7;
    run_op("r31c", 1'b1, 2'b01, 8, 8'h80, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
